// File: rtl/jk_countdown_ctrl_pkg.sv
// Shared constants for the jk flop bank controller: flop command codes and FSM states.
package jk_countdown_ctrl_pkg;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/jk_countdown_ctrl_if.sv
// Requester-side bus of the countdown timer: start/load/pause in, status and debug out.
interface jk_countdown_ctrl_if
  import jk_countdown_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   load_val;
  logic               pause;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   count;
  logic [2*WIDTH-1:0] jk_cmd;

  modport master (output start, load_val, pause, input busy, done, count, jk_cmd);
  modport slave  (input start, load_val, pause, output busy, done, count, jk_cmd);
endinterface

// File: rtl/jk_flip_flop.sv
// Existing JK flop: jk = {J,K}; 00 hold, 01 reset, 10 set, 11 toggle; sync active-high reset.
module jk_flip_flop
  import jk_countdown_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] jk,
  output logic       q,
  output logic       qbar
);
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else begin
      case (jk)
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qbar = ~q;
endmodule

// File: rtl/jk_countdown_ctrl.sv
// Loadable one-shot down-counter built on a bank of jk flops; the FSM emits per-bit jk commands.
module jk_countdown_ctrl
  import jk_countdown_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  jk_countdown_ctrl_if.slave bus
);
  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        ld_q;
  logic [WIDTH-1:0]        count_q;
  logic [WIDTH-1:0]        borrow;
  logic [WIDTH-1:0]        qbar_unused;
  logic [WIDTH-1:0][1:0]   jk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ld_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) ld_q <= bus.load_val;
    end
  end

  always_comb begin
    state_nxt = state;
    jk        = '0;
    // bit i toggles on decrement exactly when all lower bits are zero
    borrow    = '0;
    borrow[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) borrow[i] = borrow[i-1] & ~count_q[i-1];

    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;
      LOAD: begin
        for (int i = 0; i < WIDTH; i++) jk[i] = ld_q[i] ? JK_SET : JK_RST;
        state_nxt = (ld_q != '0) ? RUN : DONE;
      end
      RUN: begin
        // a zero count never decrements, so the counter cannot wrap
        if (count_q == '0) state_nxt = DONE;
        else if (!bus.pause) begin
          for (int i = 0; i < WIDTH; i++) jk[i] = borrow[i] ? JK_TGL : JK_HOLD;
          if (count_q == WIDTH'(1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ff
    jk_flip_flop u_ff (
      .clk  (clk),
      .rst  (rst),
      .jk   (jk[i]),
      .q    (count_q[i]),
      .qbar (qbar_unused[i])
    );
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.count  = count_q;
  assign bus.jk_cmd = jk;
endmodule

// File: doc/jk_countdown_ctrl.md
Name: jk_countdown_ctrl

Overview:
- Controller that sequences a bank of WIDTH existing jk_flip_flop instances as a loadable down-counter / one-shot timer.
- Each cycle the FSM computes the per-bit 2-bit jk command: load, borrow-chain decrement, or hold.
- Used as a cycle-count timer by other blocks:
  - requester pulses start with a length;
  - the block reports busy while counting and pulses done when the count reaches zero.

Parameters:
- WIDTH, 8, counter width and number of jk_flip_flop instances.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; also drives rst of every jk_flip_flop instance.
- start  input  1  request to load load_val and begin counting; honoured only in IDLE.
- load_val  input  WIDTH  initial count, sampled on the edge where start is accepted.
- pause  input  1  while high in RUN, the counter holds (all jk = 00).
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse in DONE state.
- count  output  WIDTH  q outputs of the flip-flop bank, bit i = instance i.
- jk_cmd  output  2*WIDTH  current per-bit command, bits [2i+1:2i] = {J,K} of bit i, for debug/observation.

Behaviour:
- JK encoding, fixed by the existing flop:
  - jk[1] = J, jk[0] = K;
  - 00 hold, 01 reset (q=0), 10 set (q=1), 11 toggle.
  - qbar outputs are unused.
- Reset (rst=1 at an edge):
  - state = IDLE, ld_q = 0;
  - count = 0 (flops reset);
  - busy = 0, done = 0, jk_cmd = all 00.
  - rst overrides start and pause.
  - rst mid-RUN aborts with no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - all jk = 00; count holds its last value.
  - start=1 at edge E0: ld_q <= load_val, state <= LOAD.
- LOAD:
  - bit i jk = {ld_q[i], ~ld_q[i]}.
  - At E1, count = ld_q. State <= RUN if ld_q != 0, else DONE.
  - pause is ignored in LOAD.
- RUN, pause=1: all jk = 00; count and state hold.
- RUN, pause=0 (borrow chain):
  - bit 0 jk = 11;
  - bit i>0 jk = 11 if count[i-1:0] == 0, else 00.
  - Net effect: count decrements by exactly 1 per unpaused edge.
  - When count == 1 and pause=0: next edge gives count = 0 and state <= DONE.
- DONE:
  - all jk = 00, done = 1 for exactly one cycle;
  - next edge state <= IDLE.
  - count stays 0 until the next LOAD.
- Latency: start accepted at E0 → count = V at E1 → count = 0 and state DONE at E(1+V+pauses) → done high for the following cycle → IDLE one edge later.
  - V=0: DONE directly after LOAD (done in the cycle after E1).
- Outputs:
  - busy is combinational from state (IDLE → 0).
  - done is combinational from state (DONE → 1).
- start in LOAD/RUN/DONE is ignored, with no queueing; load_val changes outside the accepting edge have no effect.
- Count never wraps below 0: RUN never issues a decrement when count == 0.

Decomposition:
- Shared package holds:
  - JK command constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11;
  - state encoding IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3.
- WIDTH instances of the existing jk_flip_flop via a generate loop. No new sub-module; next-command logic and FSM are in this module.

Test Plan:
- Reset, then load_val=5 with start pulsed one cycle, pause=0 → count 5,4,3,2,1,0 on consecutive edges; busy high from E0+1 through the DONE cycle; done high exactly 1 cycle after count reaches 0; total start-to-done = 7 edges.
- load_val=8'h80, run 1 edge → count 8'h7F; all jk_cmd bits = 11 on that edge. load_val=8'hFF → 8'hFE, only bit0 jk = 11.
- load_val=4, pause high for 3 cycles after count=2 → count holds 2 with jk_cmd all 00, then resumes 1,0; done 3 cycles later than the unpaused case.
- load_val=0 → LOAD then DONE; done pulses in the cycle after count=0; no RUN cycle; count stays 0.
- start re-pulsed with load_val=9 while counting 6 → ignored; sequence continues 5,4,...,0; next start in IDLE with 9 loads 9.
- rst asserted while count=3 in RUN → next edge count=0, busy=0, done never pulses; a subsequent start with 2 behaves normally.
